// File: rtl/bus_master_arbiter_if.sv
// Bundle of the two master request ports, the shared slave bus port and arbiter status.
// "master" is the arbiter's view; "slave" is the view of the masters/slave environment.
interface bus_master_arbiter_if;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic [1:0]  m0_sel_i;
    logic        m0_rd_i, m0_we_i, m0_ack_o;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic [1:0]  m1_sel_i;
    logic        m1_rd_i, m1_we_i, m1_ack_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [1:0]  s_sel_o;
    logic        s_rd_o, s_we_o, s_ack_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    modport master (
        input  m0_addr_i, m0_data_i, m0_sel_i, m0_rd_i, m0_we_i,
        output m0_data_o, m0_ack_o,
        input  m1_addr_i, m1_data_i, m1_sel_i, m1_rd_i, m1_we_i,
        output m1_data_o, m1_ack_o,
        output s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o,
        input  s_data_i, s_ack_i,
        output grant_o, timeout_o
    );

    modport slave (
        output m0_addr_i, m0_data_i, m0_sel_i, m0_rd_i, m0_we_i,
        input  m0_data_o, m0_ack_o,
        output m1_addr_i, m1_data_i, m1_sel_i, m1_rd_i, m1_we_i,
        input  m1_data_o, m1_ack_o,
        input  s_addr_o, s_data_o, s_sel_o, s_rd_o, s_we_o,
        output s_data_i, s_ack_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one system-bus master port between two masters,
// one outstanding transaction at a time, with a watchdog for unmapped addresses.
module bus_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_master_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic req0, req1, own, own_req, wd_fire, done;
    logic [31:0] rd_data;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        bus.s_addr_o   = '0;
        bus.s_data_o   = '0;
        bus.s_sel_o    = '0;
        bus.s_rd_o     = 1'b0;
        bus.s_we_o     = 1'b0;
        bus.m0_data_o  = '0;
        bus.m0_ack_o   = 1'b0;
        bus.m1_data_o  = '0;
        bus.m1_ack_o   = 1'b0;
        bus.grant_o    = 2'b00;
        bus.timeout_o  = 1'b0;

        req0    = bus.m0_rd_i | bus.m0_we_i;
        req1    = bus.m1_rd_i | bus.m1_we_i;
        own     = (state_q == BUSY1);
        own_req = own ? req1 : req0;
        // A master that withdrew its request is an abort, not a timeout.
        wd_fire = (cnt_q == CNT_LAST) && !bus.s_ack_i && own_req;
        done    = bus.s_ack_i || wd_fire;
        rd_data = wd_fire ? 32'h0 : bus.s_data_i;

        unique case (state_q)
            IDLE: begin
                // m0 wins alone, or on a tie when m1 was served last.
                if (req0 && (!req1 || last_q)) begin
                    state_d = BUSY0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (req1) begin
                    state_d = BUSY1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY0, BUSY1: begin
                if (own) begin
                    bus.s_addr_o = bus.m1_addr_i;
                    bus.s_data_o = bus.m1_data_i;
                    bus.s_sel_o  = bus.m1_sel_i;
                    bus.s_rd_o   = bus.m1_rd_i;
                    bus.s_we_o   = bus.m1_we_i;
                    bus.m1_data_o = rd_data;
                    bus.m1_ack_o  = done;
                    bus.grant_o   = 2'b10;
                end else begin
                    bus.s_addr_o = bus.m0_addr_i;
                    bus.s_data_o = bus.m0_data_i;
                    bus.s_sel_o  = bus.m0_sel_i;
                    bus.s_rd_o   = bus.m0_rd_i;
                    bus.s_we_o   = bus.m0_we_i;
                    bus.m0_data_o = rd_data;
                    bus.m0_ack_o  = done;
                    bus.grant_o   = 2'b01;
                end
                bus.timeout_o = wd_fire;
                if (done || !own_req) state_d = IDLE;
                else                  cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
